// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// default operand width and the counter-width helper.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake plus operand and result buses of the serial subtractor.
// The controller drives the master side; the subtractor is the slave.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             BO;

  modport master (
    output start, A, B,
    input  busy, done, D, BO
  );

  modport slave (
    input  start, A, B,
    output busy, done, D, BO
  );

endinterface

// File: rtl/serial_subtractor_half_subtractor.sv
// Half subtractor: x - y for single bits. Two of these chained on the
// borrow form the full-subtractor cell of the serial datapath.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic diff,
  output logic bor
);

  assign diff = x ^ y;
  assign bor  = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B mod 2^WIDTH, one bit per clock LSB first,
// with a borrow flip-flop and a start/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] ra_q;
  logic [WIDTH-1:0] rb_q;
  logic [WIDTH-1:0] rs_q;
  logic [WIDTH-1:0] d_q;
  logic [CNT_W-1:0] cnt_q;
  logic             borrow_q;
  logic             bo_q;
  logic             busy_q;
  logic             done_q;

  logic             diff_ab;
  logic             bor_ab;
  logic             bit_d;
  logic             bor_bin;
  logic             bout;
  logic [WIDTH-1:0] rs_d;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  half_subtractor u_hs_ab (
    .x    (ra_q[0]),
    .y    (rb_q[0]),
    .diff (diff_ab),
    .bor  (bor_ab)
  );

  half_subtractor u_hs_bin (
    .x    (diff_ab),
    .y    (borrow_q),
    .diff (bit_d),
    .bor  (bor_bin)
  );

  assign bout = bor_ab | bor_bin;

  // The new difference bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
  assign rs_d = (rs_q >> 1) | {bit_d, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ra_q     <= '0;
      rb_q     <= '0;
      rs_q     <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bo_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            ra_q     <= bus.A;
            rb_q     <= bus.B;
            rs_q     <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q  <= IDLE;
          end
        end

        RUN: begin
          ra_q     <= ra_q >> 1;
          rb_q     <= rb_q >> 1;
          rs_q     <= rs_d;
          borrow_q <= bout;
          if (cnt_q == LAST_BIT) begin
            // Counter returns to zero rather than stepping past WIDTH-1.
            cnt_q   <= '0;
            d_q     <= rs_d;
            bo_q    <= bout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.D    = d_q;
  assign bus.BO   = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed vectors,
// back-to-back and reset corner sequences, and random operands vs. a model.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full operation with random start noise and operand churn during RUN.
  // Called at #1 after a clock edge with the DUT idle; returns likewise.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_d, input logic exp_bo, input string tag);
    logic [7:0] d_before;
    int         n;
    int         busy_cycles;
    bit         d_stable;
    bit         seen_done;
    d_before    = bus.D;
    bus.start   = 1'b1;
    bus.A       = a;
    bus.B       = b;
    @(posedge clk); #1;
    check({tag, "/busy_after_accept"}, 32'(bus.busy), 32'd1);
    busy_cycles = 0;
    n           = 0;
    d_stable    = 1'b1;
    seen_done   = 1'b0;
    while (!seen_done && n < 3 * WIDTH) begin
      if (bus.busy) busy_cycles++;
      bus.start = 1'($urandom_range(0, 1));
      bus.A     = 8'($urandom);
      bus.B     = 8'($urandom);
      @(posedge clk); #1;
      n++;
      if (bus.done) seen_done = 1'b1;
      else if (bus.D !== d_before) d_stable = 1'b0;
    end
    bus.start = 1'b0;
    check({tag, "/done_seen"},   32'(seen_done),   32'd1);
    check({tag, "/latency"},     32'(n),           32'(WIDTH));
    check({tag, "/D"},           32'(bus.D),       32'(exp_d));
    check({tag, "/BO"},          32'(bus.BO),      32'(exp_bo));
    check({tag, "/busy_at_done"},32'(bus.busy),    32'd0);
    check({tag, "/busy_cycles"}, 32'(busy_cycles), 32'(WIDTH));
    check({tag, "/D_stable"},    32'(d_stable),    32'd1);
    @(posedge clk); #1;
    check({tag, "/done_pulse"},  32'(bus.done),    32'd0);
    check({tag, "/D_held"},      32'(bus.D),       32'(exp_d));
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t vecs[6];
    int   first;
    int   second;
    int   n;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       bo1;
    logic       bo2;

    vecs[0] = '{a: 8'd200,  b: 8'd55,   d: 8'h91, bo: 1'b0};
    vecs[1] = '{a: 8'd55,   b: 8'd200,  d: 8'h6F, bo: 1'b1};
    vecs[2] = '{a: 8'h00,   b: 8'h01,   d: 8'hFF, bo: 1'b1};
    vecs[3] = '{a: 8'h80,   b: 8'h80,   d: 8'h00, bo: 1'b0};
    vecs[4] = '{a: 8'hFF,   b: 8'h00,   d: 8'hFF, bo: 1'b0};
    vecs[5] = '{a: 8'h00,   b: 8'hFF,   d: 8'h01, bo: 1'b1};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #3;
    check("reset/busy", 32'(bus.busy), 32'd0);
    check("reset/done", 32'(bus.done), 32'd0);
    check("reset/D",    32'(bus.D),    32'd0);
    check("reset/BO",   32'(bus.BO),   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, $sformatf("vec%0d", i));
    end

    // Back-to-back: start held high, operands swapped after the first accept.
    bus.start = 1'b1;
    bus.A     = 8'd10;
    bus.B     = 8'd3;
    @(posedge clk); #1;
    bus.A  = 8'd3;
    bus.B  = 8'd10;
    first  = -1;
    second = -1;
    n      = 0;
    d1 = '0; d2 = '0; bo1 = 1'b0; bo2 = 1'b0;
    while (second < 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) begin
        if (first < 0) begin
          first = n; d1 = bus.D; bo1 = bus.BO;
        end else begin
          second = n; d2 = bus.D; bo2 = bus.BO;
        end
      end
    end
    bus.start = 1'b0;
    check("b2b/first_done",  32'(first),  32'd8);
    check("b2b/second_done", 32'(second), 32'd17);
    check("b2b/D1",  32'(d1),  32'h07);
    check("b2b/BO1", 32'(bo1), 32'd0);
    check("b2b/D2",  32'(d2),  32'hF9);
    check("b2b/BO2", 32'(bo2), 32'd1);
    @(posedge clk); #1;
    check("b2b/done_low", 32'(bus.done), 32'd0);
    check("b2b/idle",     32'(bus.busy), 32'd0);

    // Reset in the middle of RUN, just before bit 4 is processed.
    bus.start = 1'b1;
    bus.A     = 8'hF0;
    bus.B     = 8'h0F;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst/busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst/busy", 32'(bus.busy), 32'd0);
    check("midrst/done", 32'(bus.done), 32'd0);
    check("midrst/D",    32'(bus.D),    32'd0);
    check("midrst/BO",   32'(bus.BO),   32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst/done_held_low", 32'(bus.done), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (WIDTH + 2) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) check("midrst/no_resume", 32'({bus.busy, bus.done}), 32'd0);
    end
    run_op(8'hF0, 8'h0F, 8'hE1, 1'b0, "after_rst");

    // Random operands against a plain-arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      int         diff;
      a = 8'($urandom);
      b = (i % 8 == 0) ? a : 8'($urandom);
      diff = int'(a) - int'(b);
      run_op(a, b, 8'((diff < 0) ? diff + 256 : diff), (diff < 0), $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
